// File: rtl/sub_serial.sv
// ----------------------------------------------------------------------------
// sub_serial
//   Chunk-serial subtractor. Computes y = a - b over NCHUNK clock cycles,
//   processing CHUNK_WIDTH bits per cycle, LSB chunk first, with a rippling
//   borrow held in a register between cycles.
//
//   Operands are extended to EXT_WIDTH = NCHUNK*CHUNK_WIDTH. They are
//   sign-extended only when both A_SIGNED and B_SIGNED are set; otherwise
//   they are zero-extended. Operands wider than EXT_WIDTH are truncated.
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    operands a/b valid
//   in_ready    block idle and able to accept operands
//   a, b        minuend / subtrahend
//   out_valid   y / borrow_out valid (held until out_ready)
//   out_ready   consumer accepts the result
//   y           a - b truncated to Y_WIDTH
//   borrow_out  borrow out of the top bit of the extended width
// ----------------------------------------------------------------------------
module sub_serial #(
    parameter int A_SIGNED    = 0,
    parameter int B_SIGNED    = 0,
    parameter int A_WIDTH     = 1,
    parameter int B_WIDTH     = 1,
    parameter int Y_WIDTH     = 1,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Y_WIDTH-1:0] y,
    output logic               borrow_out
);

    localparam int NCHUNK    = (Y_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
    localparam int EXT_WIDTH = NCHUNK * CHUNK_WIDTH;
    localparam int CNT_W     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam bit SIGN_EXT  = (A_SIGNED != 0) && (B_SIGNED != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [EXT_WIDTH-1:0] a_q, a_d;
    logic [EXT_WIDTH-1:0] b_q, b_d;
    logic [EXT_WIDTH-1:0] res_q, res_d;
    logic                 bor_q, bor_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [EXT_WIDTH-1:0]   a_ext, b_ext;
    logic [CHUNK_WIDTH-1:0] a_k, b_k;
    logic [CHUNK_WIDTH:0]   diff;
    logic                   last_chunk;

    // Operand extension. The generate-if keeps out-of-range bit selects of
    // a/b from ever being elaborated.
    for (genvar i = 0; i < EXT_WIDTH; i++) begin : g_ext
        if (i < A_WIDTH) begin : g_a_in
            assign a_ext[i] = a[i];
        end else begin : g_a_pad
            assign a_ext[i] = SIGN_EXT ? a[A_WIDTH-1] : 1'b0;
        end
        if (i < B_WIDTH) begin : g_b_in
            assign b_ext[i] = b[i];
        end else begin : g_b_pad
            assign b_ext[i] = SIGN_EXT ? b[B_WIDTH-1] : 1'b0;
        end
    end

    // Input bits beyond EXT_WIDTH and result bits beyond Y_WIDTH are dropped
    // by design; fold them here so they are visibly consumed.
    logic unused_bits;
    assign unused_bits = ^{a, b, res_q};

    assign last_chunk = (cnt_q == CNT_W'(NCHUNK - 1));

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            bor_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            bor_q   <= bor_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (in_valid)   state_d = S_RUN;
            S_RUN:  if (last_chunk) state_d = S_DONE;
            S_DONE: if (out_ready)  state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    // Chunk select: pick the active CHUNK_WIDTH slice of each operand
    always_comb begin
        a_k = '0;
        b_k = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                a_k = a_q[k*CHUNK_WIDTH +: CHUNK_WIDTH];
                b_k = b_q[k*CHUNK_WIDTH +: CHUNK_WIDTH];
            end
        end
    end

    // One extra bit on the left captures the borrow: a negative chunk
    // difference wraps and sets the MSB.
    assign diff = {1'b0, a_k} - {1'b0, b_k} - {{CHUNK_WIDTH{1'b0}}, bor_q};

    // Datapath next-state
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        res_d = res_q;
        bor_d = bor_q;
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            if (in_valid) begin
                a_d   = a_ext;
                b_d   = b_ext;
                bor_d = 1'b0;
                cnt_d = '0;
            end
        end else if (state_q == S_RUN) begin
            for (int k = 0; k < NCHUNK; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    res_d[k*CHUNK_WIDTH +: CHUNK_WIDTH] = diff[CHUNK_WIDTH-1:0];
                end
            end
            bor_d = diff[CHUNK_WIDTH];
            if (!last_chunk) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign y          = res_q[Y_WIDTH-1:0];
    assign borrow_out = bor_q;

endmodule
